// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the EX-stage ALU control unit.
//   - ALUOp encodings from the main decoder
//   - 4-bit ALU Operation codes (RV32I + RV32M)
//   - funct3 constants for base and M-extension groups
//   - latency-class enum, FSM state enum and small decode helpers
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;  // load/store address add
  localparam logic [1:0] ALUOP_BR  = 2'b01;  // branch compare subtract
  localparam logic [1:0] ALUOP_R   = 2'b10;  // register-register
  localparam logic [1:0] ALUOP_I   = 2'b11;  // register-immediate

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REM  = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  // Base integer group
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // M-extension group
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    LC_NONE = 2'd0,
    LC_MUL  = 2'd1,
    LC_DIV  = 2'd2
  } lat_class_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Base-group op for a funct3, with funct7_5 treated as 0 (ADD, SRL).
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      F3_ADD_SUB: op = OP_ADD;
      F3_SLL:     op = OP_SLL;
      F3_SLT:     op = OP_SLT;
      F3_SLTU:    op = OP_SLTU;
      F3_XOR:     op = OP_XOR;
      F3_SRL_SRA: op = OP_SRL;
      F3_OR:      op = OP_OR;
      default:    op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic lat_class_e op_lat_class(input logic [3:0] op);
    lat_class_e c;
    case (op)
      OP_MUL, OP_MULH:                   c = LC_MUL;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU:  c = LC_DIV;
      default:                           c = LC_NONE;
    endcase
    return c;
  endfunction

  function automatic logic is_multicycle(input lat_class_e c);
    return c != LC_NONE;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALU control decode.
//   ALUOp, funct3, funct7_5, funct7_0 -> op (4-bit Operation code),
//   illegal (unsupported encoding), mc_class (latency class of op).
//   EN_M parameter enables the RV32M group.
//   An illegal encoding always yields op=ADD and mc_class=LC_NONE.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [1:0]  ALUOp,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        funct7_0,
  output logic [3:0]  op,
  output logic        illegal,
  output lat_class_e  mc_class
);

  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    case (ALUOp)
      ALUOP_MEM: op = OP_ADD;
      ALUOP_BR:  op = OP_SUB;
      ALUOP_R: begin
        if (funct7_0) begin
          if (!EN_M) begin
            illegal = 1'b1;
          end else begin
            case (funct3)
              F3_MUL:  op = OP_MUL;
              F3_MULH: op = OP_MULH;
              F3_DIV:  op = OP_DIV;
              F3_DIVU: op = OP_DIVU;
              F3_REM:  op = OP_REM;
              F3_REMU: op = OP_REMU;
              default: illegal = 1'b1;  // MULHSU / MULHU unsupported
            endcase
          end
        end else begin
          case (funct3)
            F3_ADD_SUB: op = funct7_5 ? OP_SUB : OP_ADD;
            F3_SRL_SRA: op = funct7_5 ? OP_SRA : OP_SRL;
            default: begin
              op      = base_op(funct3);
              illegal = funct7_5;
            end
          endcase
        end
      end
      default: begin  // ALUOP_I: funct7_0 is immediate data
        case (funct3)
          F3_ADD_SUB: op = OP_ADD;
          F3_SRL_SRA: op = funct7_5 ? OP_SRA : OP_SRL;
          F3_SLL: begin
            op      = OP_SLL;
            illegal = funct7_5;
          end
          default: op = base_op(funct3);
        endcase
      end
    endcase

    if (illegal) op = OP_ADD;
    mc_class = illegal ? LC_NONE : op_lat_class(op);
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with MUL/DIV sequencing.
//   clk, reset      rising-edge clock, async active-high reset
//   in_valid/in_ready  request handshake (accept = in_valid & in_ready & !flush)
//   ALUOp, funct3, funct7_5, funct7_0  instruction fields
//   flush           kills any in-flight multi-cycle op, drops same-cycle request
//   out_valid       one-cycle pulse after each accept
//   Operation, illegal, mc_start  decode results, held between out_valid pulses
//   busy            multi-cycle op occupying the unit
//   mc_done         pulse in the final cycle of a multi-cycle op
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter bit          EN_M    = 1'b1,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       funct7_0,
  input  logic       flush,
  output logic       out_valid,
  output logic [3:0] Operation,
  output logic       illegal,
  output logic       mc_start,
  output logic       busy,
  output logic       mc_done
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             accept;

  logic [3:0]  dec_op;
  logic        dec_illegal;
  lat_class_e  dec_class;

  alu_op_decode #(.EN_M(EN_M)) u_decode (
    .ALUOp    (ALUOp),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .funct7_0 (funct7_0),
    .op       (dec_op),
    .illegal  (dec_illegal),
    .mc_class (dec_class)
  );

  // busy/mc_done/in_ready are pure decodes of the state and counter
  // registers, so they still change only on clock or reset.
  assign cnt_zero = (cnt == '0);
  assign busy     = (state == ST_BUSY);
  assign mc_done  = (state == ST_BUSY) && cnt_zero;
  assign in_ready = (state == ST_IDLE) || cnt_zero;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      Operation <= '0;
      illegal   <= 1'b0;
      mc_start  <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        Operation <= dec_op;
        illegal   <= dec_illegal;
        mc_start  <= is_multicycle(dec_class);
      end

      if (flush) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (accept && dec_class == LC_MUL) begin
        state <= ST_BUSY;
        cnt   <= MUL_LOAD;
      end else if (accept && dec_class == LC_DIV) begin
        state <= ST_BUSY;
        cnt   <= DIV_LOAD;
      end else if (state == ST_BUSY) begin
        // Final cycle with no multi-cycle follow-on returns to idle.
        if (cnt_zero) state <= ST_IDLE;
        else          cnt   <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v_main = 1'b0, v_m0 = 1'b0, v_f = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] aluop = 2'b00;
  logic [2:0] f3 = 3'd0;
  logic       f75 = 1'b0, f70 = 1'b0;

  logic       ir, ov, il, ms, bz, md;
  logic [3:0] op;
  logic       ir0, ov0, il0, ms0, bz0, md0;
  logic [3:0] op0;
  logic       irf, ovf, ilf, msf, bzf, mdf;
  logic [3:0] opf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.EN_M(1'b1), .MUL_LAT(3), .DIV_LAT(33)) dut (
    .clk(clk), .reset(reset), .in_valid(v_main), .in_ready(ir),
    .ALUOp(aluop), .funct3(f3), .funct7_5(f75), .funct7_0(f70), .flush(flush),
    .out_valid(ov), .Operation(op), .illegal(il), .mc_start(ms),
    .busy(bz), .mc_done(md));

  alu_ctrl_seq #(.EN_M(1'b0), .MUL_LAT(3), .DIV_LAT(33)) dut_m0 (
    .clk(clk), .reset(reset), .in_valid(v_m0), .in_ready(ir0),
    .ALUOp(aluop), .funct3(f3), .funct7_5(f75), .funct7_0(f70), .flush(flush),
    .out_valid(ov0), .Operation(op0), .illegal(il0), .mc_start(ms0),
    .busy(bz0), .mc_done(md0));

  alu_ctrl_seq #(.EN_M(1'b1), .MUL_LAT(1), .DIV_LAT(2)) dut_fast (
    .clk(clk), .reset(reset), .in_valid(v_f), .in_ready(irf),
    .ALUOp(aluop), .funct3(f3), .funct7_5(f75), .funct7_0(f70), .flush(flush),
    .out_valid(ovf), .Operation(opf), .illegal(ilf), .mc_start(msf),
    .busy(bzf), .mc_done(mdf));

  // Observation vectors: {in_ready, out_valid, Operation, illegal, mc_start, busy, mc_done}
  logic [9:0] obs, obs0, obsf;
  assign obs  = {ir,  ov,  op,  il,  ms,  bz,  md};
  assign obs0 = {ir0, ov0, op0, il0, ms0, bz0, md0};
  assign obsf = {irf, ovf, opf, ilf, msf, bzf, mdf};

  function automatic logic [9:0] pk(input logic r, input logic v, input logic [3:0] o,
                                    input logic i, input logic s, input logic b, input logic d);
    return {r, v, o, i, s, b, d};
  endfunction

  task automatic drive(input logic v, input logic [1:0] a, input logic [2:0] f,
                       input logic s5, input logic s0, input logic fl);
    v_main = v; aluop = a; f3 = f; f75 = s5; f70 = s0; flush = fl;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference decode from the instruction-set tables.
  task automatic ref_decode(input logic [1:0] a, input logic [2:0] f, input logic s5,
                            input logic s0, output logic [3:0] rop, output logic rill,
                            output int lat);
    logic [3:0] rtab [8] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'h3, 4'h5, 4'h1, 4'h0};
    logic [3:0] mtab [8] = '{4'hA, 4'hB, 4'h0, 4'h0, 4'hC, 4'hD, 4'hE, 4'hF};
    rill = 1'b0;
    rop  = 4'h2;
    if (a == 2'b01) rop = 4'h6;
    else if (a == 2'b10) begin
      if (s0) begin
        if (f == 3'd2 || f == 3'd3) rill = 1'b1;
        else rop = mtab[f];
      end else if (s5) begin
        if (f == 3'd0) rop = 4'h6;
        else if (f == 3'd5) rop = 4'h7;
        else rill = 1'b1;
      end else rop = rtab[f];
    end else if (a == 2'b11) begin
      if (s5 && f == 3'd1) rill = 1'b1;
      else if (s5 && f == 3'd5) rop = 4'h7;
      else rop = rtab[f];
    end
    if (rill) rop = 4'h2;
    if (rill || rop < 4'hA) lat = 0;
    else if (rop < 4'hC) lat = 3;
    else lat = 33;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); step();
    n_cmp++;
    if (obs[8:0] !== 9'h0) begin
      n_bad++; $display("FAIL reset_hold got %h exp %h", obs[8:0], 9'h0);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (obs !== pk(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL reset_release got %h exp %h", obs, pk(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_rtype_sub();
    drive(1'b1, 2'b10, 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (obs !== pk(1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL rsub got %h exp %h", obs, pk(1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (obs !== pk(1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL rsub_hold got %h exp %h", obs, pk(1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_itype();
    logic [2:0] tf3 [3] = '{3'd5, 3'd0, 3'd1};
    logic [3:0] top [3] = '{4'h7, 4'h2, 4'h2};
    logic       til [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, tf3[i], 1'b1, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (obs !== pk(1'b1, 1'b1, top[i], til[i], 1'b0, 1'b0, 1'b0)) begin
        n_bad++; $display("FAIL itype%0d got %h exp %h", i, obs, pk(1'b1, 1'b1, top[i], til[i], 1'b0, 1'b0, 1'b0));
      end
      drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic test_mul();
    logic [9:0] e [5];
    e[0] = pk(1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0);
    e[1] = pk(1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0);
    e[2] = pk(1'b1, 1'b0, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1);
    e[3] = pk(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    e[4] = pk(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 3'd0, 1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL mul_c%0d got %h exp %h", i + 1, obs, e[i]);
      end
      if (i == 0) drive(1'b1, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
      if (i == 3) drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic test_div_flush();
    int seen;
    drive(1'b1, 2'b10, 3'd5, 1'b0, 1'b1, 1'b0);
    step();
    for (int k = 1; k <= 10; k++) begin
      n_cmp++;
      if (obs !== pk(1'b0, k == 1, 4'hD, 1'b0, 1'b1, 1'b1, 1'b0)) begin
        n_bad++; $display("FAIL divu_c%0d got %h exp %h", k, obs, pk(1'b0, k == 1, 4'hD, 1'b0, 1'b1, 1'b1, 1'b0));
      end
      if (k == 1) v_main = 1'b0;
      if (k == 10) drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1);
      step();
    end
    n_cmp++;
    if (obs !== pk(1'b1, 1'b0, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL flush_recover got %h exp %h", obs, pk(1'b1, 1'b0, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (md || bz) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL flush_no_done got %0d busy/done cycles exp 0", seen);
    end
    // Request presented together with flush in idle is dropped.
    drive(1'b1, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    n_cmp++;
    if (obs !== pk(1'b1, 1'b0, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL flush_drop got %h exp %h", obs, pk(1'b1, 1'b0, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_illegal();
    drive(1'b0, 2'b10, 3'd0, 1'b0, 1'b1, 1'b0);
    v_m0 = 1'b1;
    step();
    n_cmp++;
    if (obs0 !== pk(1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL nom_mul got %h exp %h", obs0, pk(1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    v_m0 = 1'b0;
    step();
    n_cmp++;
    if (obs0 !== pk(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL nom_nobusy got %h exp %h", obs0, pk(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    drive(1'b1, 2'b10, 3'd2, 1'b0, 1'b1, 1'b0);
    step();
    n_cmp++;
    if (obs !== pk(1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL m_f3_010 got %h exp %h", obs, pk(1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (obs !== pk(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL m_f3_010_nobusy got %h exp %h", obs, pk(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e [4];
    e[0] = pk(1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1);
    e[1] = pk(1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 1'b0);
    e[2] = pk(1'b1, 1'b0, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1);
    e[3] = pk(1'b1, 1'b0, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b10, 3'd0, 1'b0, 1'b1, 1'b0);
    v_f = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obsf !== e[i]) begin
        n_bad++; $display("FAIL b2b_c%0d got %h exp %h", i + 1, obsf, e[i]);
      end
      if (i == 0) f3 = 3'd4;
      if (i == 1) v_f = 1'b0;
      step();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b10, 3'd4, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs[8:0] !== 9'h0) begin
      n_bad++; $display("FAIL async_reset got %h exp %h", obs[8:0], 9'h0);
    end
    #1 reset = 1'b0;
    step();
    drive(1'b1, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (obs !== pk(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_bad++; $display("FAIL post_reset got %h exp %h", obs, pk(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  // Random traffic against a timeline model: an op accepted in cycle n with
  // latency L keeps the unit busy through cycle n+L.
  task automatic test_random();
    int         end_c;
    logic       m_ov, m_il, m_ms;
    logic [3:0] m_op;
    logic       v, s5, s0, fl, acc, e_ir, e_bz, e_md, rill;
    logic [1:0] a;
    logic [2:0] f;
    logic [3:0] rop;
    int         lat;
    logic [9:0] ev;
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    end_c = -1;
    m_ov = 1'b0; m_il = 1'b0; m_ms = 1'b0; m_op = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      e_bz = (end_c >= n);
      e_md = (end_c == n);
      e_ir = !(end_c > n);
      ev = pk(e_ir, m_ov, m_op, m_il, m_ms, e_bz, e_md);
      n_cmp++;
      if (obs !== ev) begin
        n_bad++; $display("FAIL random_cyc%0d got %h exp %h", n, obs, ev);
      end
      v  = ($urandom_range(0, 9) < 7);
      a  = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      f  = 3'($urandom_range(0, 7));
      s5 = 1'($urandom_range(0, 1));
      s0 = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 39) == 0);
      if (a == 2'b11 && f != 3'd0 && f != 3'd1 && f != 3'd5) s5 = 1'b0;
      if (a == 2'b10 && s0) s5 = 1'b0;
      drive(v, a, f, s5, s0, fl);
      ref_decode(a, f, s5, s0, rop, rill, lat);
      acc  = v && e_ir && !fl;
      m_ov = acc;
      if (acc) begin
        m_op = rop; m_il = rill; m_ms = (lat > 0);
      end
      if (fl) end_c = n;
      else if (acc && lat > 0) end_c = n + lat;
      step();
    end
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_itype();
    test_mul();
    test_div_flush();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
